// File: rtl/elevator_ctrl_n.sv
// Single-car N-floor elevator controller: latched calls, SCAN scheduling, SOS freeze, weight interlock.
// Build option: define DOOR_HOLD_EN to add the active-low button_hold_pushed door-hold input.
module elevator_ctrl_n #(
    parameter int N_FLOORS      = 3,
    parameter int TRAVEL_CYCLES = 50000000,
    parameter int DOOR_CYCLES   = 100000000,
    parameter int MAX_PEOPLE    = 6,
    parameter int CNT_W         = 27
) (
    input  logic                clk_50,
    input  logic                button_reset_pushed,
    input  logic [N_FLOORS-1:0] button_pushed,
    input  logic                sos_flip,
    input  logic                weight_flip,
    input  logic                weight_flip_reset,
`ifdef DOOR_HOLD_EN
    input  logic                button_hold_pushed,
`endif
    output logic [N_FLOORS-1:0] led,
    output logic [N_FLOORS-1:0] floor,
    output logic                door,
    output logic                moving,
    output logic                dir_up,
    output logic                sos_mode,
    output logic                weight_limit_exceeded
);
    localparam int unsigned     NF          = N_FLOORS;
    localparam int              IW          = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1;
    localparam int              OW          = $clog2(MAX_PEOPLE + 2);
    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [IW-1:0]   TOP_FLOOR   = IW'(N_FLOORS - 1);
    localparam logic [OW-1:0]   OCC_SAT     = OW'(MAX_PEOPLE + 1);
    localparam logic [OW-1:0]   OCC_LIM     = OW'(MAX_PEOPLE);

    typedef enum logic [1:0] {IDLE, MOVE, DOOR_OPEN, SOS} state_t;

    state_t               state, state_n;
    logic [IW-1:0]        cur, cur_n, nxt;
    logic                 dir_n;
    logic [CNT_W-1:0]     timer, timer_n;
    logic [N_FLOORS-1:0]  req_set, req_clr, led_n;
    logic [N_FLOORS-1:0]  btn_s1, btn_s2, pressed;
    logic                 sos_s1, sos_s2;
    logic                 wf_s1, wf_s2, wf_s3;
    logic                 wr_s1, wr_s2, wr_s3;
    logic [OW-1:0]        occ;
    logic                 hold_req;

    function automatic logic any_above(input logic [N_FLOORS-1:0] m, input logic [IW-1:0] idx);
        logic r;
        r = 1'b0;
        for (int unsigned i = 0; i < NF; i++)
            if (i > 32'(idx) && m[i]) r = 1'b1;
        return r;
    endfunction

    function automatic logic any_below(input logic [N_FLOORS-1:0] m, input logic [IW-1:0] idx);
        logic r;
        r = 1'b0;
        for (int unsigned i = 0; i < NF; i++)
            if (i < 32'(idx) && m[i]) r = 1'b1;
        return r;
    endfunction

    // Synchronisers park at the inactive level so reset never looks like a press.
    always_ff @(posedge clk_50) begin
        if (!button_reset_pushed) begin
            btn_s1 <= '1;
            btn_s2 <= '1;
            sos_s1 <= 1'b0;
            sos_s2 <= 1'b0;
            wf_s1  <= 1'b0;
            wf_s2  <= 1'b0;
            wf_s3  <= 1'b0;
            wr_s1  <= 1'b0;
            wr_s2  <= 1'b0;
            wr_s3  <= 1'b0;
        end else begin
            btn_s1 <= button_pushed;
            btn_s2 <= btn_s1;
            sos_s1 <= sos_flip;
            sos_s2 <= sos_s1;
            wf_s1  <= weight_flip;
            wf_s2  <= wf_s1;
            wf_s3  <= wf_s2;
            wr_s1  <= weight_flip_reset;
            wr_s2  <= wr_s1;
            wr_s3  <= wr_s2;
        end
    end

    assign pressed = ~btn_s2;

`ifdef DOOR_HOLD_EN
    logic hold_s1, hold_s2;
    always_ff @(posedge clk_50) begin
        if (!button_reset_pushed) begin
            hold_s1 <= 1'b1;
            hold_s2 <= 1'b1;
        end else begin
            hold_s1 <= button_hold_pushed;
            hold_s2 <= hold_s1;
        end
    end
    assign hold_req = ~hold_s2;
`else
    assign hold_req = 1'b0;
`endif

    always_ff @(posedge clk_50) begin
        if (!button_reset_pushed) begin
            occ                   <= '0;
            weight_limit_exceeded <= 1'b0;
        end else begin
            if (wr_s2 && !wr_s3)
                occ <= '0;
            else if (wf_s2 && !wf_s3 && occ != OCC_SAT)
                occ <= occ + OW'(1);
            weight_limit_exceeded <= (occ > OCC_LIM);
        end
    end

    always_ff @(posedge clk_50) begin
        if (!button_reset_pushed) begin
            state  <= IDLE;
            cur    <= '0;
            dir_up <= 1'b1;
            timer  <= '0;
            led    <= '0;
        end else begin
            state  <= state_n;
            cur    <= cur_n;
            dir_up <= dir_n;
            timer  <= timer_n;
            led    <= led_n;
        end
    end

    always_comb begin
        state_n = state;
        cur_n   = cur;
        nxt     = cur;
        dir_n   = dir_up;
        timer_n = timer;
        req_set = pressed;
        req_clr = '0;
        if (sos_s2) begin
            state_n = SOS;
            timer_n = '0;
            req_set = '0;
            req_clr = '1;
        end else begin
            case (state)
                IDLE: begin
                    timer_n = '0;
                    if (led[cur]) begin
                        state_n      = DOOR_OPEN;
                        req_clr[cur] = 1'b1;
                    end else if (|led && !weight_limit_exceeded) begin
                        dir_n   = dir_up ? any_above(led, cur) : !any_below(led, cur);
                        state_n = MOVE;
                    end
                end
                MOVE: begin
                    if (timer == TRAVEL_LAST) begin
                        timer_n = '0;
                        if (dir_up && cur != TOP_FLOOR)
                            nxt = cur + IW'(1);
                        else if (!dir_up && cur != '0)
                            nxt = cur - IW'(1);
                        cur_n = nxt;
                        if (led[nxt]) begin
                            state_n      = DOOR_OPEN;
                            req_clr[nxt] = 1'b1;
                        end else if (!(dir_up ? any_above(led, nxt) : any_below(led, nxt))) begin
                            state_n = IDLE;
                        end
                    end else begin
                        timer_n = timer + CNT_W'(1);
                    end
                end
                DOOR_OPEN: begin
                    // A call at the open floor only extends the dwell; it is never latched.
                    req_set[cur] = 1'b0;
                    if (pressed[cur] || weight_limit_exceeded || hold_req) begin
                        timer_n = '0;
                    end else if (timer == DOOR_LAST) begin
                        timer_n = '0;
                        state_n = IDLE;
                    end else begin
                        timer_n = timer + CNT_W'(1);
                    end
                end
                SOS: begin
                    timer_n = '0;
                    req_set = '0;
                    req_clr = '1;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
        led_n = (led | req_set) & ~req_clr;
    end

    always_comb begin
        floor      = '0;
        floor[cur] = 1'b1;
    end

    assign door     = (state == DOOR_OPEN);
    assign moving   = (state == MOVE);
    assign sos_mode = (state == SOS);

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Directed bench for elevator_ctrl_n: a 3-floor instance for the main scenarios, an 8-floor one for scan order and reset abort.
module tb_elevator_ctrl_n;
    logic       clk = 1'b0;
    logic       rst, sos, wf, wr;
    logic [2:0] btn, led, flr;
    logic       door, moving, dir_up, sos_mode, wle;

    logic       rst8, sos8, wf8, wr8;
    logic [7:0] btn8, led8, flr8;
    logic       door8, moving8, dir8, sos_mode8, wle8;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    elevator_ctrl_n #(.N_FLOORS(3), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3), .MAX_PEOPLE(6), .CNT_W(8)) u_dut (
        .clk_50(clk), .button_reset_pushed(rst), .button_pushed(btn), .sos_flip(sos),
        .weight_flip(wf), .weight_flip_reset(wr), .led(led), .floor(flr), .door(door),
        .moving(moving), .dir_up(dir_up), .sos_mode(sos_mode), .weight_limit_exceeded(wle)
    );

    elevator_ctrl_n #(.N_FLOORS(8), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3), .MAX_PEOPLE(6), .CNT_W(8)) u_dut8 (
        .clk_50(clk), .button_reset_pushed(rst8), .button_pushed(btn8), .sos_flip(sos8),
        .weight_flip(wf8), .weight_flip_reset(wr8), .led(led8), .floor(flr8), .door(door8),
        .moving(moving8), .dir_up(dir8), .sos_mode(sos_mode8), .weight_limit_exceeded(wle8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press3(input int idx);
        btn[idx] = 1'b0;
        tick();
        btn = '1;
        tick();
        tick();
    endtask

    task automatic wait_door(input string tag, input logic want, input int limit);
        int k = 0;
        while (door !== want && k < limit) begin
            tick();
            k++;
        end
        chk(tag, 32'(door), 32'(want));
    endtask

    task automatic wait_door8(input string tag, input logic want, input int limit);
        int k = 0;
        while (door8 !== want && k < limit) begin
            tick();
            k++;
        end
        chk(tag, 32'(door8), 32'(want));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; btn = '1; sos = 1'b0; wf = 1'b0; wr = 1'b0;
        rst8 = 1'b0; btn8 = '1; sos8 = 1'b0; wf8 = 1'b0; wr8 = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (10) tick();
        chk("reset_floor", 32'(flr), 32'h1);
        chk("reset_led", 32'(led), 32'h0);
        chk("reset_door", 32'(door), 32'h0);
        chk("reset_moving", 32'(moving), 32'h0);
        chk("reset_dir", 32'(dir_up), 32'h1);
        chk("reset_sos", 32'(sos_mode), 32'h0);
        chk("reset_wle", 32'(wle), 32'h0);

        // Call to floor 2: two floors of 4 cycles each, then a 3-cycle dwell.
        press3(2);
        chk("a_led", 32'(led), 32'b100);
        chk("a_idle", 32'(moving), 32'h0);
        tick();
        chk("a_move_start", 32'(moving), 32'h1);
        chk("a_floor_start", 32'(flr), 32'b001);
        repeat (4) tick();
        chk("a_floor1", 32'(flr), 32'b010);
        chk("a_moving_mid", 32'(moving), 32'h1);
        repeat (4) tick();
        chk("a_floor2", 32'(flr), 32'b100);
        chk("a_door_open", 32'(door), 32'h1);
        chk("a_stopped", 32'(moving), 32'h0);
        chk("a_led_cleared", 32'(led), 32'b000);
        repeat (2) tick();
        chk("a_dwell", 32'(door), 32'h1);
        tick();
        chk("a_door_closed", 32'(door), 32'h0);
        chk("a_dir", 32'(dir_up), 32'h1);

        // Descent: calls 0 then 1, with 2 arriving during the trip.
        press3(0);
        chk("b_led0", 32'(led), 32'b001);
        chk("b_idle", 32'(moving), 32'h0);
        press3(1);
        chk("b_led01", 32'(led), 32'b011);
        chk("b_moving", 32'(moving), 32'h1);
        chk("b_dir_down", 32'(dir_up), 32'h0);
        wait_door("b_door1", 1'b1, 10);
        chk("b_floor1", 32'(flr), 32'b010);
        chk("b_led_after1", 32'(led), 32'b001);
        press3(2);
        chk("b_led_pending", 32'(led), 32'b101);
        wait_door("b_door0", 1'b1, 20);
        chk("b_floor0", 32'(flr), 32'b001);
        chk("b_dir0", 32'(dir_up), 32'h0);
        chk("b_led_after0", 32'(led), 32'b100);
        wait_door("b_close0", 1'b0, 10);
        wait_door("b_door2", 1'b1, 30);
        chk("b_floor2", 32'(flr), 32'b100);
        chk("b_dir_up", 32'(dir_up), 32'h1);
        chk("b_led_empty", 32'(led), 32'b000);
        wait_door("b_close2", 1'b0, 10);

        // Overload holds the door open until the count is cleared.
        btn[2] = 1'b0;
        repeat (4) tick();
        chk("c_door", 32'(door), 32'h1);
        for (int i = 0; i < 7; i++) begin
            wf = 1'b1;
            tick();
            wf = 1'b0;
            tick();
        end
        repeat (4) tick();
        chk("c_wle", 32'(wle), 32'h1);
        chk("c_door_held", 32'(door), 32'h1);
        btn = '1;
        repeat (12) tick();
        chk("c_door_stays", 32'(door), 32'h1);
        chk("c_led_not_latched", 32'(led), 32'b000);
        chk("c_wle_still", 32'(wle), 32'h1);
        wr = 1'b1;
        tick();
        wr = 1'b0;
        repeat (3) tick();
        chk("c_wle_clr", 32'(wle), 32'h0);
        chk("c_door_after_clr", 32'(door), 32'h1);
        repeat (2) tick();
        chk("c_dwell_end", 32'(door), 32'h1);
        tick();
        chk("c_door_closed", 32'(door), 32'h0);

        // SOS during travel 0 -> 1.
        press3(0);
        wait_door("d_door0", 1'b1, 20);
        chk("d_floor0", 32'(flr), 32'b001);
        wait_door("d_close0", 1'b0, 10);
        press3(2);
        tick();
        chk("d_moving", 32'(moving), 32'h1);
        chk("d_dir_up", 32'(dir_up), 32'h1);
        sos = 1'b1;
        repeat (3) tick();
        chk("d_sos_mode", 32'(sos_mode), 32'h1);
        chk("d_sos_stopped", 32'(moving), 32'h0);
        chk("d_sos_led", 32'(led), 32'b000);
        chk("d_sos_floor", 32'(flr), 32'b001);
        chk("d_sos_door", 32'(door), 32'h0);
        press3(1);
        tick();
        chk("d_btn_ignored", 32'(led), 32'b000);
        chk("d_still_sos", 32'(sos_mode), 32'h1);
        sos = 1'b0;
        repeat (3) tick();
        chk("d_sos_exit", 32'(sos_mode), 32'h0);
        chk("d_dir_kept", 32'(dir_up), 32'h1);
        chk("d_exit_idle", 32'(moving), 32'h0);
        chk("d_exit_floor", 32'(flr), 32'b001);

        // Eight floors: calls 7 and 3 from ground, then reset mid-travel.
        rst8 = 1'b1;
        repeat (2) tick();
        chk("e_reset_floor", 32'(flr8), 32'h01);
        btn8 = 8'b0111_0111;
        tick();
        btn8 = '1;
        tick();
        tick();
        chk("e_led", 32'(led8), 32'b1000_1000);
        wait_door8("e_door3", 1'b1, 40);
        chk("e_floor3", 32'(flr8), 32'b0000_1000);
        chk("e_led_after3", 32'(led8), 32'b1000_0000);
        wait_door8("e_close3", 1'b0, 10);
        wait_door8("e_door7", 1'b1, 40);
        chk("e_floor7", 32'(flr8), 32'b1000_0000);
        chk("e_led_after7", 32'(led8), 32'h00);
        wait_door8("e_close7", 1'b0, 10);
        btn8[0] = 1'b0;
        tick();
        btn8 = '1;
        repeat (3) tick();
        repeat (2) tick();
        chk("e_moving", 32'(moving8), 32'h1);
        chk("e_floor_mid", 32'(flr8), 32'b1000_0000);
        rst8 = 1'b0;
        tick();
        chk("e_abort_floor", 32'(flr8), 32'h01);
        chk("e_abort_moving", 32'(moving8), 32'h0);
        chk("e_abort_led", 32'(led8), 32'h00);
        chk("e_abort_dir", 32'(dir8), 32'h1);
        rst8 = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
